// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control FSM sequencing reads, ALU op, writeback and status update
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   s         start request, sampled only while idle (WAIT)
//   opcode    instruction class: 110 = MOV, 101 = ALU
//   op        sub-op; forwarded as the ALU operation for class 101
//   w         idle/ready, high only in WAIT
//   done      one-cycle pulse in the final state of a legal instruction
//   err       one-cycle pulse for an illegal opcode/op pair
//   nsel      one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm
//   vsel      writeback source: 00 = C, 10 = sign-extended imm8
//   write     register-file write enable
//   loada     A pipeline register load
//   loadb     B pipeline register load
//   loadc     C pipeline register load
//   loads     status register load
//   asel      forces the ALU A operand to zero
//   bsel      selects sximm5 for the ALU B operand (never used here)
//   alu_op    ALU operation select

module alu_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic       done,
    output logic       err,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] alu_op
);

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] SUB_MOV_REG = 2'b00;
    localparam logic [1:0] SUB_MOV_IMM = 2'b10;
    localparam logic [1:0] SUB_ADD     = 2'b00;
    localparam logic [1:0] SUB_CMP     = 2'b01;
    localparam logic [1:0] SUB_AND     = 2'b10;
    localparam logic [1:0] SUB_MVN     = 2'b11;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_WRITE_IMM = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_ALU       = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] opcode_q;
    logic [1:0] op_q;

    logic       lat_is_mov;
    logic       lat_is_cmp;

    // Classification of the latched instruction; only meaningful once the
    // FSM has left WAIT, since the latch is loaded on the accept edge.
    assign lat_is_mov = (opcode_q == OPC_MOV);
    assign lat_is_cmp = (opcode_q == OPC_ALU) && (op_q == SUB_CMP);

    // First state after acceptance, decided from the live opcode/op since
    // the latch only becomes visible on the same edge that leaves WAIT.
    function automatic state_t entry_state(input logic [2:0] opc, input logic [1:0] sub);
        state_t nxt;
        nxt = ST_ERR;
        if (opc == OPC_MOV) begin
            if (sub == SUB_MOV_IMM)
                nxt = ST_WRITE_IMM;
            else if (sub == SUB_MOV_REG)
                nxt = ST_GET_B;
        end else if (opc == OPC_ALU) begin
            case (sub)
                SUB_ADD, SUB_AND, SUB_CMP: nxt = ST_GET_A;
                SUB_MVN:                   nxt = ST_GET_B;
                default:                   nxt = ST_ERR;
            endcase
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state <= state_next;
            if (state == ST_WAIT && s) begin
                opcode_q <= opcode;
                op_q     <= op;
            end
        end
    end

    // Next-state and Moore output decode. Outputs depend only on state and
    // the latched fields, so an async reset drops every strobe immediately.
    always_comb begin
        state_next = state;
        w          = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        nsel       = 3'b000;
        vsel       = VSEL_C;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        alu_op     = 2'b00;

        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s)
                    state_next = entry_state(opcode, op);
            end

            ST_WRITE_IMM: begin
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                done       = 1'b1;
                state_next = ST_WAIT;
            end

            ST_GET_A: begin
                nsel       = NSEL_RN;
                loada      = 1'b1;
                state_next = ST_GET_B;
            end

            ST_GET_B: begin
                nsel       = NSEL_RM;
                loadb      = 1'b1;
                state_next = ST_ALU;
            end

            ST_ALU: begin
                if (lat_is_mov) begin
                    // MOV Rd,Rm is computed as 0 + Rm through the adder.
                    alu_op     = 2'b00;
                    asel       = 1'b1;
                    loadc      = 1'b1;
                    state_next = ST_WRITE_REG;
                end else if (lat_is_cmp) begin
                    // CMP only updates status; there is no writeback.
                    alu_op     = SUB_CMP;
                    loads      = 1'b1;
                    done       = 1'b1;
                    state_next = ST_WAIT;
                end else begin
                    alu_op     = op_q;
                    loadc      = 1'b1;
                    state_next = ST_WRITE_REG;
                end
            end

            ST_WRITE_REG: begin
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                done       = 1'b1;
                state_next = ST_WAIT;
            end

            ST_ERR: begin
                err        = 1'b1;
                state_next = ST_WAIT;
            end

            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard testbench for alu_sequencer

module tb_alu_sequencer;

    logic       clk;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, done, err;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] alu_op;

    alu_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .done    (done),
        .err     (err),
        .nsel    (nsel),
        .vsel    (vsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .alu_op  (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector: {w, done, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op}
    logic [16:0] exp_q[$];

    function automatic logic [16:0] bv(input logic w_, input logic d, input logic e,
                                       input logic [2:0] ns, input logic [1:0] vs,
                                       input logic wr, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as_,
                                       input logic [1:0] ao);
        return {w_, d, e, ns, vs, wr, la, lb, lc, ls, as_, 1'b0, ao};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {w, done, err, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h at %0t", name, got, want, $time);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int want);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    endtask

    // Reference model: each instruction is a fixed list of named steps.
    task automatic push_expected(input logic [2:0] opc, input logic [1:0] o);
        logic [16:0] v_geta, v_getb, v_alu, v_alu_mov, v_cmp, v_wr, v_imm, v_err;
        v_geta    = bv(0, 0, 0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00);
        v_getb    = bv(0, 0, 0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00);
        v_alu     = bv(0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, o);
        v_alu_mov = bv(0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00);
        v_cmp     = bv(0, 1, 0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01);
        v_wr      = bv(0, 1, 0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00);
        v_imm     = bv(0, 1, 0, 3'b001, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00);
        v_err     = bv(0, 0, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        if (opc == 3'b110 && o == 2'b10) begin
            exp_q.push_back(v_imm);
        end else if (opc == 3'b110 && o == 2'b00) begin
            exp_q.push_back(v_getb); exp_q.push_back(v_alu_mov); exp_q.push_back(v_wr);
        end else if (opc == 3'b101 && (o == 2'b00 || o == 2'b10)) begin
            exp_q.push_back(v_geta); exp_q.push_back(v_getb); exp_q.push_back(v_alu); exp_q.push_back(v_wr);
        end else if (opc == 3'b101 && o == 2'b01) begin
            exp_q.push_back(v_geta); exp_q.push_back(v_getb); exp_q.push_back(v_cmp);
        end else if (opc == 3'b101 && o == 2'b11) begin
            exp_q.push_back(v_getb); exp_q.push_back(v_alu); exp_q.push_back(v_wr);
        end else begin
            exp_q.push_back(v_err);
        end
    endtask

    logic [16:0] idle_vec;
    initial idle_vec = bv(1, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);

    // Monitor: compares every cycle on the falling edge.
    always @(negedge clk) begin
        logic [16:0] cur;
        int strobes;
        cur = dut_vec();
        strobes = int'(write) + int'(loada) + int'(loadb) + int'(loadc) + int'(loads);
        n_cmp++;
        if (strobes > 1) begin
            n_bad++;
            $display("FAIL strobe_exclusive: got %0d strobes want <=1 at %0t", strobes, $time);
        end
        if (w) begin
            if (exp_q.size() != 0) begin
                fail_now("early_return_to_wait", 0, exp_q.size());
                exp_q.delete();
            end else begin
                check("idle_outputs", cur, idle_vec);
            end
        end else if (exp_q.size() == 0) begin
            check("unexpected_busy", cur, idle_vec);
        end else begin
            check("busy_step", cur, exp_q.pop_front());
        end
    end

    // Issue one instruction: wait for WAIT (bounded), optionally idle some
    // cycles, then request. While busy, s/opcode/op get noise if asked.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                             input bit noisy, input int gap);
        int g;
        bit ok;
        g = gap;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w) begin
                if (g == 0) begin
                    ok = 1'b1;
                    break;
                end
                g--;
                s = 1'b0;
            end else begin
                s      = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                opcode = noisy ? 3'($urandom) : 3'b000;
                op     = noisy ? 2'($urandom) : 2'b00;
            end
        end
        if (!ok) begin
            fail_now("wait_timeout", 0, 1);
        end else begin
            s      = 1'b1;
            opcode = opc;
            op     = o;
            @(posedge clk);
            #1;
            push_expected(opc, o);
        end
    endtask

    initial begin
        logic [2:0] r_opc;
        logic [1:0] r_op;
        int pick;
        logic [2:0] legal_opc [6];
        logic [1:0] legal_op  [6];
        legal_opc = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
        legal_op  = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};

        reset_n = 1'b0;
        s       = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;
        #1;
        check("reset_outputs", dut_vec(), idle_vec);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Directed: MOV imm, ADD, CMP, illegal, MVN with noise, MOV reg, AND.
        run_instr(3'b110, 2'b10, 1'b0, 0);
        run_instr(3'b101, 2'b00, 1'b0, 1);
        run_instr(3'b101, 2'b01, 1'b0, 0);
        run_instr(3'b110, 2'b01, 1'b0, 0);
        run_instr(3'b101, 2'b11, 1'b1, 0);
        run_instr(3'b110, 2'b00, 1'b0, 2);
        run_instr(3'b101, 2'b10, 1'b0, 0);

        // Async reset during GET_B of ADD.
        run_instr(3'b101, 2'b00, 1'b0, 0);
        s = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_add", dut_vec(), idle_vec);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(3'b101, 2'b00, 1'b0, 0);

        // Randomized traffic, including illegal pairs and busy-time noise.
        for (int k = 0; k < 300; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                r_opc = legal_opc[pick % 6];
                r_op  = legal_op[pick % 6];
                if (pick == 6) begin
                    pick  = $urandom_range(0, 5);
                    r_opc = legal_opc[pick];
                    r_op  = legal_op[pick];
                end
            end else begin
                r_opc = 3'($urandom);
                r_op  = 2'($urandom);
            end
            run_instr(r_opc, r_op, 1'b1, $urandom_range(0, 2));
        end

        // Drain.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s = 1'b0;
            if (w && exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM for the 16-bit RISC datapath. Accepts one decoded instruction at a time (opcode, op) on a start/wait handshake, then sequences register-file reads into A/B, the ALU operation (add, sub, and, not-B), writeback into the register file, and the status-register update for compares. Sits between the instruction register/decoder and the datapath. It drives every load, select and write strobe. It never touches data values.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; one clock domain
- s  in  1  start request; sampled only in WAIT
- opcode  in  3  instruction class: 110 = MOV, 101 = ALU
- op  in  2  sub-op; passed to ALU as ALUop for class 101
- w  out  1  idle/ready; high only in WAIT
- done  out  1  one-cycle pulse in the final state of a legal instruction
- err  out  1  one-cycle pulse for an illegal opcode/op pair
- nsel  out  3  one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm; 000 when idle
- vsel  out  2  writeback source: 00 = C, 10 = sign-extended imm8; 00 when not writing
- write  out  1  register-file write enable
- loada, loadb, loadc, loads  out  1 each  pipeline register / status load enables
- asel  out  1  1 forces the ALU A operand to 16'b0
- bsel  out  1  1 selects sximm5 for the ALU B operand; always 0 in this block
- alu_op  out  2  ALUop to the ALU

## Operation
- Outputs are Moore: they decode from the state and the latched fields only. They carry no combinational path from s, opcode or op.
- Acceptance: in WAIT with s = 1 at a rising edge, opcode and op are latched into internal registers. The sequence then runs from the latch. Changes on opcode/op while busy have no effect.
- States: WAIT, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, ERR.
- Legal sequences from WAIT:
  - MOV Rn,#imm (110/10): WRITE_IMM -> WAIT
  - MOV Rd,Rm (110/00): GET_B -> ALU -> WRITE_REG -> WAIT
  - ADD (101/00), AND (101/10): GET_A -> GET_B -> ALU -> WRITE_REG -> WAIT
  - CMP (101/01): GET_A -> GET_B -> ALU -> WAIT
  - MVN (101/11): GET_B -> ALU -> WRITE_REG -> WAIT
  - Any other opcode/op pair: ERR -> WAIT
- Per-state outputs (anything not listed is 0):
  - WAIT: w = 1
  - WRITE_IMM: nsel = 001, vsel = 10, write = 1, done = 1
  - GET_A: nsel = 001, loada = 1
  - GET_B: nsel = 100, loadb = 1
  - ALU for MOV: alu_op = 00, asel = 1, loadc = 1
  - ALU for 101/00, 101/10, 101/11: alu_op = latched op, loadc = 1
  - ALU for CMP: alu_op = 01, loads = 1, loadc = 0, done = 1
  - WRITE_REG: nsel = 010, vsel = 00, write = 1, done = 1
  - ERR: err = 1
- At most one of write, loada, loadb, loadc, loads is high in any cycle.
- nsel is exactly one-hot whenever write, loada or loadb is high.
- s is ignored outside WAIT; no request is queued. If s is held high through a return to WAIT, the next instruction is accepted on the first edge in WAIT.

## Timing
- Reset (reset_n low): state forced to WAIT immediately, without waiting for a clock edge. Outputs then read w = 1 and all other outputs 0 (nsel = 000, vsel = 00, alu_op = 00). Latched opcode/op reset to 0.
- Reset asserted mid-sequence: any in-progress write or load deasserts within the same cycle. No partial writeback completes after reset asserts.
- Busy cycles from the accept edge to w high again:
  - MOV imm: 1
  - ERR: 1
  - MOV reg: 3
  - MVN: 3
  - CMP: 3
  - ADD: 4
  - AND: 4
- Back-to-back throughput is 1 WAIT cycle plus the busy cycles.
- The ALU's zero output is captured by the status register on the edge that leaves the CMP ALU state. Z is valid in the cycle when w returns high.
- The register-file write occurs on the edge that leaves WRITE_IMM or WRITE_REG.

## Test plan
- Reset release with s = 0 -> w = 1, all strobes 0, nsel = 000 for 10 cycles. Asserting reset_n low between edges -> outputs go to reset values before the next edge.
- MOV R0,#7 (110/10, s pulsed 1 cycle) -> exactly one cycle with write = 1, nsel = 001, vsel = 10, done = 1. w is low 1 cycle. R0 reads 7.
- ADD R2,R1,R0 with R1 = 5, R0 = 7 -> cycle-by-cycle sequence loada(nsel 001), loadb(nsel 100), loadc(alu_op 00), write(nsel 010). R2 reads 12 and w is low 4 cycles.
- CMP R0,R0 (101/01) -> loads high in the ALU state with alu_op = 01. write is never asserted, Z = 1 after return, and w is low 3 cycles.
- Illegal 110/01 -> single err pulse, no load or write strobe, back in WAIT after 1 cycle. Also: opcode changed to 101/00 during a MVN sequence -> the MVN sequence still completes unchanged.
- reset_n pulsed low during the GET_B state of ADD -> no write occurs, w = 1 after release, and a new s accepts normally.
